mm_stream_core: RTL and testbench

- Parametrised single-clock successor of the matrix-multiply datapath: streams in two DIM x DIM unsigned matrices, one element of each per valid cycle, in row-major order.
- Computes C = A*B, or C = A*B^T when selected, and streams C out row-major, one element per cycle.
- Sits behind the clock-domain-crossing front end as the compute core; all interfaces are on one clock.

---
 rtl/mm_pkg.sv | 15 +
 rtl/mm_dot.sv | 21 ++
 rtl/mm_stream_core.sv | 138 +++++++++++++
 tb/tb_mm_stream_core.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and width helpers for the streaming matrix-multiply core.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Result width that holds a full DIM-term sum of DW x DW products.
    function automatic int unsigned calc_ow(input int unsigned dim, input int unsigned dw);
        return 2 * dw + $clog2(dim);
    endfunction

endpackage

// File: rtl/mm_dot.sv
// Combinational unsigned dot product of two DIM-element vectors.
module mm_dot
    import mm_pkg::*;
#(
    parameter int unsigned  DIM = 4,
    parameter int unsigned  DW  = 4,
    localparam int unsigned OW  = calc_ow(DIM, DW)
) (
    input  logic [DIM*DW-1:0] a,
    input  logic [DIM*DW-1:0] b,
    output logic [OW-1:0]     dot
);

    always_comb begin
        dot = '0;
        for (int k = 0; k < int'(DIM); k++) begin
            dot = dot + OW'(a[k*DW +: DW]) * OW'(b[k*DW +: DW]);
        end
    end

endmodule

// File: rtl/mm_stream_core.sv
// Streaming DIM x DIM matrix multiply: loads A and B row-major, emits C = A*B or A*B^T.
module mm_stream_core
    import mm_pkg::*;
#(
    parameter int unsigned  DIM = 4,
    parameter int unsigned  DW  = 4,
    localparam int unsigned OW  = calc_ow(DIM, DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_mode,
    input  logic [DW-1:0] in_matrix_A,
    input  logic [DW-1:0] in_matrix_B,
    output logic          out_valid,
    output logic [OW-1:0] out_matrix
);

    localparam int unsigned   N    = DIM * DIM;
    localparam int unsigned   CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          state, state_d;
    logic [CW-1:0]   ld_cnt, ld_cnt_d;
    logic [CW-1:0]   out_cnt, out_cnt_d;
    logic            mode, mode_d;
    logic            out_valid_d;
    logic [OW-1:0]   out_matrix_d;
    logic            wr_en;

    logic [DW-1:0]   mem_a [N];
    logic [DW-1:0]   mem_b [N];

    logic [CW-1:0]   row, col;
    logic [DIM*DW-1:0] a_vec, b_vec;
    logic [OW-1:0]   dot;

    // Operand gather for element out_cnt: row of A against column of B (or row of B when transposed).
    always_comb begin
        row   = out_cnt / CW'(DIM);
        col   = out_cnt % CW'(DIM);
        a_vec = '0;
        b_vec = '0;
        for (int k = 0; k < int'(DIM); k++) begin
            a_vec[k*DW +: DW] = mem_a[CW'(32'(row) * DIM + 32'(k))];
            if (mode) begin
                b_vec[k*DW +: DW] = mem_b[CW'(32'(col) * DIM + 32'(k))];
            end else begin
                b_vec[k*DW +: DW] = mem_b[CW'(32'(k) * DIM + 32'(col))];
            end
        end
    end

    mm_dot #(
        .DIM (DIM),
        .DW  (DW)
    ) u_dot (
        .a   (a_vec),
        .b   (b_vec),
        .dot (dot)
    );

    // Next-state and registered-output values. C[0][0] never reads the final
    // beat, so it is registered on the same edge that stores that beat.
    always_comb begin
        state_d      = state;
        ld_cnt_d     = ld_cnt;
        out_cnt_d    = out_cnt;
        mode_d       = mode;
        wr_en        = 1'b0;
        out_valid_d  = 1'b0;
        out_matrix_d = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    mode_d   = in_mode;
                    ld_cnt_d = CW'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (ld_cnt == LAST) begin
                        ld_cnt_d     = '0;
                        out_cnt_d    = CW'(1);
                        out_valid_d  = 1'b1;
                        out_matrix_d = dot;
                        state_d      = OUT;
                    end else begin
                        ld_cnt_d = ld_cnt + CW'(1);
                    end
                end
            end
            OUT: begin
                out_valid_d  = 1'b1;
                out_matrix_d = dot;
                if (out_cnt == LAST) begin
                    out_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    out_cnt_d = out_cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ld_cnt     <= '0;
            out_cnt    <= '0;
            mode       <= 1'b0;
            out_valid  <= 1'b0;
            out_matrix <= '0;
        end else begin
            state      <= state_d;
            ld_cnt     <= ld_cnt_d;
            out_cnt    <= out_cnt_d;
            mode       <= mode_d;
            out_valid  <= out_valid_d;
            out_matrix <= out_matrix_d;
        end
    end

    // Operand storage; contents are don't-care until fully loaded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_a[ld_cnt] <= in_matrix_A;
            mem_b[ld_cnt] <= in_matrix_B;
        end
    end

endmodule

// File: tb/tb_mm_stream_core.sv
// Directed/randomized bench for mm_stream_core against a plain-arithmetic matrix model.
module tb_mm_stream_core;

    localparam int unsigned DIM = 4;
    localparam int unsigned DW  = 4;
    localparam int unsigned OW  = 10;
    localparam int unsigned N   = DIM * DIM;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_mode;
    logic [DW-1:0] in_matrix_A;
    logic [DW-1:0] in_matrix_B;
    logic          out_valid;
    logic [OW-1:0] out_matrix;

    int checks;
    int errors;

    int unsigned a_m [N];
    int unsigned b_m [N];
    int unsigned exp_c [N];
    int          gap [N];

    mm_stream_core #(
        .DIM (DIM),
        .DW  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_mode     (in_mode),
        .in_matrix_A (in_matrix_A),
        .in_matrix_B (in_matrix_B),
        .out_valid   (out_valid),
        .out_matrix  (out_matrix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: C[i][j] = sum_k A[i][k] * X[k][j], X = B or B^T.
    task automatic model(input bit mode);
        for (int i = 0; i < int'(DIM); i++) begin
            for (int j = 0; j < int'(DIM); j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < int'(DIM); k++) begin
                    s += a_m[i*DIM+k] * (mode ? b_m[j*DIM+k] : b_m[k*DIM+j]);
                end
                exp_c[i*DIM+j] = s;
            end
        end
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < int'(N); i++) gap[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair, then check the output stream; abort_at >= 0 resets after that many outputs.
    task automatic run_pair(input bit mode, input int abort_at);
        model(mode);
        for (int i = 0; i < int'(N); i++) begin
            in_valid    = 1'b1;
            in_matrix_A = DW'(a_m[i]);
            in_matrix_B = DW'(b_m[i]);
            in_mode     = (i == 0) ? mode : 1'($urandom);
            tick();
            in_valid    = 1'b0;
            in_mode     = 1'($urandom);
            in_matrix_A = DW'($urandom);
            in_matrix_B = DW'($urandom);
            if (i < int'(N) - 1) begin
                check("load_quiet", 32'(out_valid), 32'd0);
                for (int g = 0; g < gap[i]; g++) begin
                    tick();
                    check("gap_quiet", 32'(out_valid), 32'd0);
                end
            end
        end
        for (int e = 0; e < int'(N); e++) begin
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_data", 32'(out_matrix), 32'd0);
                tick();
                check("rst_hold_valid", 32'(out_valid), 32'd0);
                rst_n = 1'b1;
                tick();
                return;
            end
            check($sformatf("out_valid[%0d]", e), 32'(out_valid), 32'd1);
            check($sformatf("out_data[%0d]", e), 32'(out_matrix), 32'(exp_c[e]));
            tick();
        end
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_data", 32'(out_matrix), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_mode     = 1'b0;
        in_matrix_A = '0;
        in_matrix_B = '0;
        clear_gaps();
        repeat (3) tick();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_matrix), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Identity times ramp, mode 0.
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = (i / int'(DIM) == i % int'(DIM)) ? 1 : 0;
            b_m[i] = i;
        end
        run_pair(1'b0, -1);
        repeat (2) tick();

        // Max values.
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = 15;
            b_m[i] = 15;
        end
        run_pair(1'b0, -1);

        // Transpose mode, started back-to-back.
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = (i / int'(DIM) == i % int'(DIM)) ? 1 : 0;
            b_m[i] = i;
        end
        run_pair(1'b1, -1);
        repeat (3) tick();

        // Gapped input.
        gap[5]  = 3;
        gap[11] = 3;
        run_pair(1'b0, -1);
        clear_gaps();

        // Random pairs, back-to-back, random modes and gaps.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < int'(N); i++) begin
                a_m[i] = $urandom_range(0, 15);
                b_m[i] = $urandom_range(0, 15);
                gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            run_pair(1'($urandom), -1);
        end
        clear_gaps();

        // Reset after the 6th output, then all-ones pair.
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = $urandom_range(0, 15);
            b_m[i] = $urandom_range(0, 15);
        end
        run_pair(1'b1, 6);
        for (int i = 0; i < int'(N); i++) begin
            a_m[i] = 1;
            b_m[i] = 1;
        end
        run_pair(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
